ncsp_ramp_gen: RTL

- Frequency-word ramp generator that sits directly upstream of the MASH top.
- Drives the integer word and the 24-bit fractional word (msb/isb/lsb bytes) into the MASH input stage, so the fractional-N synthesizer can sweep frequency for FMCW chirps.
- Supports single sawtooth, continuous sawtooth and continuous triangle ramps, with programmable step size, step count, per-step dwell and end-point hold.

---
 rtl/ncsp_ramp_gen.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ncsp_ramp_gen.sv
// Frequency-word ramp generator driving the MASH integer/fractional inputs.
// Sawtooth (single/continuous) and triangle chirps with per-step dwell and end-point hold.
module ncsp_ramp_gen #(
  parameter int unsigned STEP_CNT_W = 16,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned HOLD_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [1:0]            i_mode,
  input  logic [31:0]           i_start_word,
  input  logic [23:0]           i_step,
  input  logic [STEP_CNT_W-1:0] i_num_steps,
  input  logic [DWELL_W-1:0]    i_dwell,
  input  logic [HOLD_W-1:0]     i_hold,
  output logic [7:0]            o_int,
  output logic [7:0]            o_msb,
  output logic [7:0]            o_isb,
  output logic [7:0]            o_lsb,
  output logic                  o_busy,
  output logic                  o_dir,
  output logic                  o_ramp_done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STEP_W = 24;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RAMP_UP  = 3'd1;
  localparam logic [2:0] S_HOLD_TOP = 3'd2;
  localparam logic [2:0] S_RAMP_DN  = 3'd3;
  localparam logic [2:0] S_HOLD_BOT = 3'd4;

  localparam logic [1:0] MODE_CONT_SAW = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;

  logic [2:0]            state_q, state_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic                  busy_q, busy_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic [DWELL_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  cfg_load;

  logic [1:0]            mode_q;
  logic [WORD_W-1:0]     start_word_q;
  logic [STEP_W-1:0]     step_q;
  logic [STEP_CNT_W-1:0] num_steps_q;
  logic [DWELL_W-1:0]    dwell_q;
  logic [HOLD_W-1:0]     hold_q;

  logic [WORD_W-1:0]     step_ext_c;
  logic [WORD_W:0]       word_sum_c;
  logic [WORD_W-1:0]     word_inc_c;
  logic [WORD_W-1:0]     word_dec_c;
  logic [STEP_CNT_W-1:0] step_cnt_inc_c;
  logic                  dwell_last_c;
  logic                  step_last_c;
  logic                  hold_last_c;
  logic                  no_steps_c;

  // Saturating step arithmetic, evaluated every cycle against the latched step.
  assign step_ext_c     = WORD_W'(step_q);
  assign word_sum_c     = {1'b0, word_q} + {1'b0, step_ext_c};
  assign word_inc_c     = word_sum_c[WORD_W] ? '1 : word_sum_c[WORD_W-1:0];
  assign word_dec_c     = (word_q < step_ext_c) ? '0 : (word_q - step_ext_c);
  assign step_cnt_inc_c = step_cnt_q + STEP_CNT_W'(1);
  assign dwell_last_c   = (dwell_cnt_q == dwell_q);
  assign step_last_c    = (step_cnt_inc_c == num_steps_q);
  assign hold_last_c    = (hold_cnt_q == hold_q);
  assign no_steps_c     = (num_steps_q == '0);

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    busy_d      = busy_q;
    dir_d       = dir_q;
    done_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    step_cnt_d  = step_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    cfg_load    = 1'b0;

    if (i_abort) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      dir_d       = 1'b1;
      dwell_cnt_d = '0;
      step_cnt_d  = '0;
      hold_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cfg_load    = 1'b1;
            word_d      = i_start_word;
            busy_d      = 1'b1;
            dir_d       = 1'b1;
            dwell_cnt_d = '0;
            step_cnt_d  = '0;
            hold_cnt_d  = '0;
            state_d     = (i_num_steps == '0) ? S_HOLD_TOP : S_RAMP_UP;
          end
        end

        S_RAMP_UP, S_RAMP_DN: begin
          if (dwell_last_c) begin
            dwell_cnt_d = '0;
            word_d      = (state_q == S_RAMP_UP) ? word_inc_c : word_dec_c;
            if (step_last_c) begin
              step_cnt_d = '0;
              hold_cnt_d = '0;
              state_d    = (state_q == S_RAMP_UP) ? S_HOLD_TOP : S_HOLD_BOT;
            end else begin
              step_cnt_d = step_cnt_inc_c;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end

        S_HOLD_TOP: begin
          if (hold_last_c) begin
            hold_cnt_d = '0;
            case (mode_q)
              MODE_CONT_SAW: begin
                word_d  = start_word_q;
                done_d  = 1'b1;
                state_d = no_steps_c ? S_HOLD_TOP : S_RAMP_UP;
              end
              MODE_TRIANGLE: begin
                dir_d   = 1'b0;
                state_d = no_steps_c ? S_HOLD_BOT : S_RAMP_DN;
              end
              default: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            endcase
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end

        // Bottom end point is not reloaded; the next up edge starts from here.
        S_HOLD_BOT: begin
          if (hold_last_c) begin
            hold_cnt_d = '0;
            dir_d      = 1'b1;
            done_d     = 1'b1;
            state_d    = no_steps_c ? S_HOLD_TOP : S_RAMP_UP;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          dir_d   = 1'b1;
        end
      endcase
    end
  end

  // State, word, counters and configuration registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      busy_q       <= 1'b0;
      dir_q        <= 1'b1;
      done_q       <= 1'b0;
      dwell_cnt_q  <= '0;
      step_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      mode_q       <= '0;
      start_word_q <= '0;
      step_q       <= '0;
      num_steps_q  <= '0;
      dwell_q      <= '0;
      hold_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
      done_q      <= done_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_cnt_q  <= step_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      if (cfg_load) begin
        mode_q       <= i_mode;
        start_word_q <= i_start_word;
        step_q       <= i_step;
        num_steps_q  <= i_num_steps;
        dwell_q      <= i_dwell;
        hold_q       <= i_hold;
      end
    end
  end

  assign o_int       = word_q[31:24];
  assign o_msb       = word_q[23:16];
  assign o_isb       = word_q[15:8];
  assign o_lsb       = word_q[7:0];
  assign o_busy      = busy_q;
  assign o_dir       = dir_q;
  assign o_ramp_done = done_q;

endmodule
